// File: rtl/el2_pkg.sv
// Shared EL2 types: retire trace packet and trace capture buffer entry.
package el2_pkg;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  typedef struct packed {
    logic        marker;
    logic [31:0] insn;
    logic [31:0] address;
    logic        exception;
    logic [4:0]  ecause;
    logic        interrupt;
    logic [31:0] tval;
  } el2_trace_buf_entry_t;

  typedef enum logic {
    NORMAL,
    DROP
  } el2_trace_buf_state_t;

endpackage

// File: rtl/el2_trace_buf.sv
// Retire-trace FIFO: drops on overflow and later injects a marker
// entry whose tval carries the number of packets lost.
module el2_trace_buf
  import el2_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_en,
  input  el2_trace_pkt_t           in_pkt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_marker,
  output el2_trace_pkt_t           out_pkt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropping
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  el2_trace_buf_entry_t r_mem [DEPTH];
  el2_trace_buf_state_t r_state;
  el2_trace_buf_state_t w_state_nxt;

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     w_level_nxt;
  logic              r_valid;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [DROP_W-1:0] w_cnt_nxt;
  logic [DROP_W-1:0] w_cnt_inc;
  logic [DROP_W-1:0] w_mark_cnt;

  logic w_qual;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_mark;

  el2_trace_buf_entry_t w_entry;
  el2_trace_buf_entry_t w_head;

  assign w_qual = in_pkt.trace_rv_i_valid_ip & trace_en;
  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = r_valid & out_ready;

  assign w_cnt_inc  = (r_drop_cnt == '1) ? r_drop_cnt
                                         : r_drop_cnt + DROP_W'(1);
  assign w_mark_cnt = w_qual ? w_cnt_inc : r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_drop_cnt;
    w_push      = 1'b0;
    w_mark      = 1'b0;
    unique case (r_state)
      NORMAL: begin
        if (w_qual) begin
          if (w_full) begin
            w_state_nxt = DROP;
            w_cnt_nxt   = DROP_W'(1);
          end else begin
            w_push = 1'b1;
          end
        end
      end
      DROP: begin
        if (w_full) begin
          if (w_qual) w_cnt_nxt = w_cnt_inc;
        end else begin
          // marker absorbs any input arriving this cycle
          w_push      = 1'b1;
          w_mark      = 1'b1;
          w_state_nxt = NORMAL;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_entry = '0;
    if (w_mark) begin
      w_entry.marker = 1'b1;
      w_entry.tval   = 32'(w_mark_cnt);
    end else begin
      w_entry.insn      = in_pkt.trace_rv_i_insn_ip;
      w_entry.address   = in_pkt.trace_rv_i_address_ip;
      w_entry.exception = in_pkt.trace_rv_i_exception_ip;
      w_entry.ecause    = in_pkt.trace_rv_i_ecause_ip;
      w_entry.interrupt = in_pkt.trace_rv_i_interrupt_ip;
      w_entry.tval      = in_pkt.trace_rv_i_tval_ip;
    end
  end

  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= NORMAL;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_valid    <= (w_level_nxt != '0);
      r_drop_cnt <= w_cnt_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= w_entry;
  end

  assign w_head = r_mem[r_rptr];

  always_comb begin
    out_pkt    = '0;
    out_marker = 1'b0;
    if (r_valid) begin
      out_marker                      = w_head.marker;
      out_pkt.trace_rv_i_insn_ip      = w_head.insn;
      out_pkt.trace_rv_i_address_ip   = w_head.address;
      out_pkt.trace_rv_i_valid_ip     = 1'b1;
      out_pkt.trace_rv_i_exception_ip = w_head.exception;
      out_pkt.trace_rv_i_ecause_ip    = w_head.ecause;
      out_pkt.trace_rv_i_interrupt_ip = w_head.interrupt;
      out_pkt.trace_rv_i_tval_ip      = w_head.tval;
    end
  end

  assign out_valid = r_valid;
  assign level     = r_level;
  assign dropping  = (r_state == DROP);

endmodule

// File: tb/tb_el2_trace_buf.sv
// Directed vector table plus corner sequences for el2_trace_buf
// at DEPTH=4, DROP_W=16.
module tb_el2_trace_buf;
  import el2_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           trace_en;
  el2_trace_pkt_t in_pkt;
  logic           out_valid;
  logic           out_ready;
  logic           out_marker;
  el2_trace_pkt_t out_pkt;
  logic [2:0]     level;
  logic           dropping;

  int n_vec = 0;
  int n_mis = 0;

  el2_trace_buf #(.DEPTH(4), .DROP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .in_pkt     (in_pkt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_marker (out_marker),
    .out_pkt    (out_pkt),
    .level      (level),
    .dropping   (dropping)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        v;
    logic [31:0] addr;
    logic        rdy;
    logic        ov;
    logic        om;
    logic [31:0] val;
    logic [2:0]  lvl;
    logic        drp;
  } vec_t;

  vec_t tbl[$];

  function automatic el2_trace_pkt_t mkpkt(input logic [31:0] a);
    el2_trace_pkt_t p;
    p.trace_rv_i_insn_ip      = {a[15:0], 16'hBEEF};
    p.trace_rv_i_address_ip   = a;
    p.trace_rv_i_valid_ip     = 1'b1;
    p.trace_rv_i_exception_ip = a[2];
    p.trace_rv_i_ecause_ip    = a[6:2];
    p.trace_rv_i_interrupt_ip = a[3];
    p.trace_rv_i_tval_ip      = ~a;
    return p;
  endfunction

  function automatic el2_trace_pkt_t mkmark(input logic [31:0] n);
    el2_trace_pkt_t p;
    p = '0;
    p.trace_rv_i_valid_ip = 1'b1;
    p.trace_rv_i_tval_ip  = n;
    return p;
  endfunction

  task automatic add(input logic r, e, v, input logic [31:0] a,
                     input logic rd, ov, om, input logic [31:0] val,
                     input logic [2:0] l, input logic d);
    vec_t x;
    x.rst = r; x.en = e; x.v = v; x.addr = a; x.rdy = rd;
    x.ov = ov; x.om = om; x.val = val; x.lvl = l; x.drp = d;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic r, e, v, input logic [31:0] a,
                       input logic rd);
    el2_trace_pkt_t p;
    p = mkpkt(a);
    p.trace_rv_i_valid_ip = v;
    rst = r; trace_en = e; in_pkt = p; out_ready = rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, want);
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chkp(input string nm, input el2_trace_pkt_t got, want);
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 0, 0);
    step();
    drive(0, 1, 0, 0, 0);
  endtask

  initial begin
    el2_trace_pkt_t exp_p;
    el2_trace_pkt_t prev_p;
    logic           prev_ov, prev_rd, prev_om;
    logic [31:0]    q[$];
    logic [31:0]    seq;
    logic [31:0]    mt;
    logic           seen;
    logic           v, rd;

    // rst en v addr rdy | ov om val lvl drp
    add(1, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 1, 'h100,  1, 1, 0, 'h100,  1, 0);
    add(0, 1, 1, 'h104,  1, 1, 0, 'h104,  1, 0);
    add(0, 1, 1, 'h108,  1, 1, 0, 'h108,  1, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 1, 'h200,  0, 1, 0, 'h200,  1, 0);
    add(0, 1, 1, 'h204,  0, 1, 0, 'h200,  2, 0);
    add(0, 1, 1, 'h208,  0, 1, 0, 'h200,  3, 0);
    add(0, 1, 1, 'h20C,  0, 1, 0, 'h200,  4, 0);
    add(0, 1, 1, 'h210,  0, 1, 0, 'h200,  4, 1);
    add(0, 1, 1, 'h214,  0, 1, 0, 'h200,  4, 1);
    add(0, 1, 1, 'h218,  0, 1, 0, 'h200,  4, 1);
    add(0, 1, 0, 0,      1, 1, 0, 'h204,  3, 1);
    add(0, 1, 0, 0,      1, 1, 0, 'h208,  3, 0);
    add(0, 1, 0, 0,      1, 1, 0, 'h20C,  2, 0);
    add(0, 1, 0, 0,      1, 1, 1, 3,      1, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 1, 'h300,  0, 1, 0, 'h300,  1, 0);
    add(0, 1, 1, 'h304,  0, 1, 0, 'h300,  2, 0);
    add(0, 1, 1, 'h308,  0, 1, 0, 'h300,  3, 0);
    add(0, 1, 1, 'h30C,  0, 1, 0, 'h300,  4, 0);
    add(0, 1, 1, 'h310,  0, 1, 0, 'h300,  4, 1);
    add(0, 1, 1, 'h314,  0, 1, 0, 'h300,  4, 1);
    add(0, 1, 0, 0,      1, 1, 0, 'h304,  3, 1);
    add(0, 1, 1, 'h3FF,  0, 1, 0, 'h304,  4, 0);
    add(0, 1, 0, 0,      1, 1, 0, 'h308,  3, 0);
    add(0, 1, 0, 0,      1, 1, 0, 'h30C,  2, 0);
    add(0, 1, 0, 0,      1, 1, 1, 3,      1, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 0, 1, 'h900,  1, 0, 0, 0,      0, 0);
    add(0, 0, 1, 'h904,  1, 0, 0, 0,      0, 0);
    add(0, 0, 1, 'h908,  1, 0, 0, 0,      0, 0);
    add(0, 1, 1, 'h500,  0, 1, 0, 'h500,  1, 0);
    add(0, 1, 1, 'h504,  0, 1, 0, 'h500,  2, 0);
    add(0, 1, 1, 'h508,  0, 1, 0, 'h500,  3, 0);
    add(0, 1, 1, 'h50C,  0, 1, 0, 'h500,  4, 0);
    add(0, 1, 1, 'h510,  0, 1, 0, 'h500,  4, 1);
    add(0, 0, 1, 'h514,  1, 1, 0, 'h504,  3, 1);
    add(0, 0, 1, 'h518,  0, 1, 0, 'h504,  4, 0);
    add(0, 1, 0, 0,      1, 1, 0, 'h508,  3, 0);
    add(0, 1, 0, 0,      1, 1, 0, 'h50C,  2, 0);
    add(0, 1, 0, 0,      1, 1, 1, 1,      1, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 1, 'h400,  0, 1, 0, 'h400,  1, 0);
    add(0, 1, 1, 'h404,  0, 1, 0, 'h400,  2, 0);
    add(0, 1, 1, 'h408,  0, 1, 0, 'h400,  3, 0);
    add(0, 1, 1, 'h40C,  0, 1, 0, 'h400,  4, 0);
    add(0, 1, 1, 'h410,  0, 1, 0, 'h400,  4, 1);
    add(1, 1, 1, 'h414,  0, 0, 0, 0,      0, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);
    add(0, 1, 0, 0,      1, 0, 0, 0,      0, 0);

    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].addr, tbl[i].rdy);
      step();
      n_vec++;
      exp_p = '0;
      if (tbl[i].ov)
        exp_p = tbl[i].om ? mkmark(tbl[i].val) : mkpkt(tbl[i].val);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d out_marker", i), 32'(out_marker), 32'(tbl[i].om));
      chk($sformatf("v%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d dropping", i), 32'(dropping), 32'(tbl[i].drp));
      chkp($sformatf("v%0d out_pkt", i), out_pkt, exp_p);
    end

    // saturation: 70000 drops against a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 32'h600 + 32'(i * 4), 0);
      step();
    end
    for (int i = 0; i < 70000; i++) begin
      drive(0, 1, 1, 32'h700, 0);
      step();
    end
    n_vec++;
    chk("sat dropping", 32'(dropping), 1);
    chk("sat level", 32'(level), 4);
    drive(0, 1, 0, 0, 1);
    seen = 1'b0;
    mt = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid && out_marker) begin
        seen = 1'b1;
        mt = out_pkt.trace_rv_i_tval_ip;
      end
      step();
    end
    n_vec++;
    chk("sat marker seen", 32'(seen), 1);
    chk("sat marker tval", mt, 32'h0000FFFF);

    // random backpressure against an in-order scoreboard
    do_reset();
    seq = 32'h1000;
    prev_ov = 1'b0;
    prev_rd = 1'b0;
    prev_om = 1'b0;
    prev_p = '0;
    for (int c = 0; c < 600; c++) begin
      rd = ($urandom % 3) == 0;
      v  = ($urandom % 4) != 0;
      if (c >= 500) begin
        v = 1'b0;
        rd = 1'b1;
      end
      if (prev_ov && !prev_rd) begin
        n_vec++;
        chkp("bp hold pkt", out_pkt, prev_p);
        chk("bp hold marker", 32'(out_marker), 32'(prev_om));
      end
      if (out_valid && rd) begin
        n_vec++;
        if (out_marker) begin
          mt = out_pkt.trace_rv_i_tval_ip;
          if (mt == 0 || mt > 32'(q.size())) begin
            n_mis++;
            $display("FAIL bp marker count: got %0d queued %0d", mt, q.size());
          end else begin
            for (int k = 0; k < int'(mt); k++) void'(q.pop_front());
          end
        end else if (q.size() == 0) begin
          n_mis++;
          $display("FAIL bp extra output: got %h expected none",
                   out_pkt.trace_rv_i_address_ip);
        end else begin
          chkp("bp order", out_pkt, mkpkt(q.pop_front()));
        end
      end
      if (v) begin
        q.push_back(seq);
        drive(0, 1, 1, seq, rd);
        seq = seq + 4;
      end else begin
        drive(0, 1, 0, 0, rd);
      end
      prev_ov = out_valid;
      prev_rd = rd;
      prev_om = out_marker;
      prev_p  = out_pkt;
      step();
    end
    n_vec++;
    chk("bp leftover inputs", 32'(q.size()), 0);
    chk("bp drained", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
